// File: rtl/hub75_pkg.sv
// hub75_pkg: shared types and widths for the HUB-75 scan path.
// Sequencer states and position-bus widths.
package hub75_pkg;

  localparam int kRowBits   = 5;
  localparam int kFrameBits = 10;

  typedef enum logic [2:0] {
    kIdle,
    kPrime,
    kPrimeArm,
    kRun,
    kArm,
    kWait,
    kBlank
  } SeqState;

endpackage

// File: rtl/cascade_counter.sv
// cascade_counter: wrap-at-MAX counter with carry chaining.
// carry_out is high on the increment that wraps back to zero.
module cascade_counter #(
  parameter int W = 4,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         carry_in,
  output logic [W-1:0] count,
  output logic         carry_out
);

  assign carry_out = carry_in & (count == MAX);

  // advance on carry_in, wrapping to zero after MAX
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (carry_in) begin
      count <= carry_out ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/row_sequencer.sv
// row_sequencer: HUB-75 row-slot scheduler.
// Keeps generator one slot ahead of driver across two RAM banks.
module row_sequencer
  import hub75_pkg::*;
#(
  parameter int ROW_COUNT    = 32,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  output logic                  gen_start,
  input  logic                  gen_is_idle,
  output logic [kRowBits-1:0]   gen_y,
  output logic [kFrameBits-1:0] gen_frame_count,
  output logic                  drv_start,
  input  logic                  drv_is_idle,
  output logic [kRowBits-1:0]   drv_y,
  output logic [kFrameBits-1:0] drv_frame_count,
  output logic                  row_done,
  output logic                  frame_done,
  output logic                  busy
);

  localparam int kFrameW = kFrameBits - 1;
  localparam int kBlankW = 4;
  localparam logic [kRowBits-1:0] kRowMax =
    kRowBits'(ROW_COUNT - 1);
  localparam logic [kBlankW-1:0] kBlankMax =
    kBlankW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);

  SeqState state;
  SeqState state_nx;

  logic [kRowBits-1:0] row;
  logic [kRowBits-1:0] row_next;
  logic [kFrameW-1:0]  frame;
  logic [kFrameW-1:0]  frame_next;
  logic [kBlankW-1:0]  blank_cnt;
  logic bank;
  logic both_idle;
  logic advance;
  logic row_wrap;
  logic frame_wrap;
  logic blank_end;
  logic primed;
  logic gen_start_nx;
  logic drv_start_nx;
  logic unused_ok;

  assign both_idle = gen_is_idle & drv_is_idle;
  assign advance   = (state == kWait) & both_idle;

  cascade_counter #(
    .W   (kRowBits),
    .MAX (kRowMax)
  ) u_row (
    .clock     (clock),
    .reset     (reset),
    .carry_in  (advance),
    .count     (row),
    .carry_out (row_wrap)
  );

  cascade_counter #(
    .W   (kFrameW),
    .MAX ({kFrameW{1'b1}})
  ) u_frame (
    .clock     (clock),
    .reset     (reset),
    .carry_in  (row_wrap),
    .count     (frame),
    .carry_out (frame_wrap)
  );

  cascade_counter #(
    .W   (kBlankW),
    .MAX (kBlankMax)
  ) u_blank (
    .clock     (clock),
    .reset     (reset),
    .carry_in  (state == kBlank),
    .count     (blank_cnt),
    .carry_out (blank_end)
  );

  assign unused_ok = ^{frame_wrap, blank_cnt};

  // bank flips once per completed slot
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bank <= 1'b0;
    end else if (advance) begin
      bank <= ~bank;
    end
  end

  // next-state and start-pulse decode
  always_comb begin
    state_nx = state;
    unique case (state)
      kIdle:     if (enable) state_nx = kPrime;
      kPrime:    state_nx = kPrimeArm;
      kPrimeArm: if (gen_is_idle) state_nx = kRun;
      kRun:      state_nx = kArm;
      kArm:      state_nx = kWait;
      kWait: begin
        if (both_idle) begin
          if (BLANK_CYCLES == 0) begin
            state_nx = enable ? kRun : kIdle;
          end else begin
            state_nx = kBlank;
          end
        end
      end
      kBlank:    if (blank_end) state_nx = enable ? kRun : kIdle;
      default:   state_nx = kIdle;
    endcase
    drv_start_nx = (state_nx == kRun);
    gen_start_nx = enable &
      ((state == kIdle) | (state_nx == kRun));
  end

  // state and registered start pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= kIdle;
      gen_start <= 1'b0;
      drv_start <= 1'b0;
    end else begin
      state     <= state_nx;
      gen_start <= gen_start_nx;
      drv_start <= drv_start_nx;
    end
  end

  // while priming, the generator fills the current slot
  always_comb begin
    primed = (state == kIdle) | (state == kPrime) |
             (state == kPrimeArm);
    row_next   = (row == kRowMax) ? '0 : row + 1'b1;
    frame_next = (row == kRowMax) ? frame + 1'b1 : frame;
    gen_y           = primed ? row : row_next;
    gen_frame_count = primed ? {frame, bank}
                             : {frame_next, ~bank};
  end

  assign drv_y           = row;
  assign drv_frame_count = {frame, bank};
  assign row_done        = advance;
  assign frame_done      = advance & (row == kRowMax);
  assign busy            = (state != kIdle);

endmodule

// File: tb/tb_row_sequencer.sv
// tb_row_sequencer: randomized scenarios for row_sequencer.
// Stage models and a slot-index scoreboard supply expectations.
module tb_row_sequencer;

  localparam int ROW   = 32;
  localparam int BLANK = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic gen_is_idle = 1'b1;
  logic drv_is_idle = 1'b1;
  logic gen_start;
  logic drv_start;
  logic [4:0] gen_y;
  logic [4:0] drv_y;
  logic [9:0] gen_frame_count;
  logic [9:0] drv_frame_count;
  logic row_done;
  logic frame_done;
  logic busy;

  always #5 clock = ~clock;

  row_sequencer #(
    .ROW_COUNT    (ROW),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .gen_start       (gen_start),
    .gen_is_idle     (gen_is_idle),
    .gen_y           (gen_y),
    .gen_frame_count (gen_frame_count),
    .drv_start       (drv_start),
    .drv_is_idle     (drv_is_idle),
    .drv_y           (drv_y),
    .drv_frame_count (drv_frame_count),
    .row_done        (row_done),
    .frame_done      (frame_done),
    .busy            (busy)
  );

  typedef struct {
    int         cyc;
    int         k;
    bit         paired;
    logic [4:0] y;
    logic [9:0] fc;
  } ev_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gen_lo = 64, gen_hi = 64;
  int drv_lo = 130, drv_hi = 130;
  int gen_left = 0, drv_left = 0;
  bit gen_seen = 0, drv_seen = 0;
  bit outstanding = 0;
  int rd_count = 0, fd_count = 0;
  int rd_err = 0, fd_err = 0;
  int gen_viol = 0, drv_viol = 0;
  ev_t gq[$];
  ev_t dq[$];

  function automatic logic [4:0] slot_y(input int k);
    return 5'(k % ROW);
  endfunction

  function automatic logic [9:0] slot_fc(input int k);
    logic [8:0] f;
    f = 9'((k / ROW) % 512);
    return {f, 1'(k % 2)};
  endfunction

  // observer: records start pulses, checks handshake rules
  initial forever begin
    bit exp_rd;
    @(negedge clock);
    cyc++;
    if (!reset) begin
      outstanding = 0;
      gen_seen = 0;
      drv_seen = 0;
    end else begin
      exp_rd = outstanding && gen_is_idle && drv_is_idle;
      if (row_done !== exp_rd) rd_err++;
      if (frame_done !==
          (exp_rd && (rd_count % ROW == ROW - 1))) fd_err++;
      if (row_done) begin
        rd_count++;
        outstanding = 0;
      end
      if (frame_done) fd_count++;
      if (gen_start) begin
        if (!gen_is_idle) gen_viol++;
        gq.push_back('{cyc, rd_count, drv_start,
                       gen_y, gen_frame_count});
        gen_seen = 1;
      end
      if (drv_start) begin
        if (!drv_is_idle) drv_viol++;
        dq.push_back('{cyc, rd_count, 1'b1,
                       drv_y, drv_frame_count});
        drv_seen = 1;
        outstanding = 1;
      end
    end
  end

  // stage models: busy for a random span after each start
  initial forever begin
    @(posedge clock);
    #1;
    if (!reset) begin
      gen_is_idle = 1; drv_is_idle = 1;
      gen_left = 0; drv_left = 0;
    end else begin
      if (gen_seen) begin
        gen_seen = 0;
        gen_is_idle = 0;
        gen_left = $urandom_range(gen_hi, gen_lo);
      end else if (gen_left > 0) begin
        gen_left--;
        if (gen_left == 0) gen_is_idle = 1;
      end
      if (drv_seen) begin
        drv_seen = 0;
        drv_is_idle = 0;
        drv_left = $urandom_range(drv_hi, drv_lo);
      end else if (drv_left > 0) begin
        drv_left--;
        if (drv_left == 0) drv_is_idle = 1;
      end
    end
  end

  task automatic wait_drv(input int n, input int budget);
    for (int i = 0; i < budget && dq.size() < n; i++) begin
      @(negedge clock); #1;
    end
    if (dq.size() < n) begin
      checks++; failures++;
      $display("FAIL drv_start_timeout got=%0d req=%0d",
               dq.size(), n);
    end
  endtask

  task automatic wait_gen(input int n, input int budget);
    for (int i = 0; i < budget && gq.size() < n; i++) begin
      @(negedge clock); #1;
    end
    if (gq.size() < n) begin
      checks++; failures++;
      $display("FAIL gen_start_timeout got=%0d req=%0d",
               gq.size(), n);
    end
  endtask

  task automatic test_reset;
    reset = 0; enable = 0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    checks++;
    if ({gen_start, drv_start, row_done, frame_done, busy,
         gen_y, drv_y, gen_frame_count, drv_frame_count}
        !== 35'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h req=0",
        {gen_start, drv_start, row_done, frame_done, busy,
         gen_y, drv_y, gen_frame_count, drv_frame_count});
    end
    @(posedge clock); #1;
    reset = 1;
    repeat (100) @(negedge clock);
    #1;
    checks++;
    if (gq.size() + dq.size() !== 0) begin
      failures++;
      $display("FAIL idle_no_start got=%0d req=0",
               gq.size() + dq.size());
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy got=%b req=0", busy);
    end
    checks++;
    if ({gen_y, drv_y, gen_frame_count, drv_frame_count}
        !== 30'd0) begin
      failures++;
      $display("FAIL idle_position got=%h req=0",
        {gen_y, drv_y, gen_frame_count, drv_frame_count});
    end
  endtask

  task automatic test_prime;
    int t0;
    gen_lo = 64; gen_hi = 64; drv_lo = 130; drv_hi = 130;
    @(posedge clock); #1;
    t0 = cyc;
    enable = 1;
    wait_gen(1, 20);
    if (gq.size() >= 1) begin
      checks++;
      if (gq[0].cyc !== t0 + 2) begin
        failures++;
        $display("FAIL prime_latency got=%0d req=%0d",
                 gq[0].cyc - t0, 2);
      end
      checks++;
      if ({gq[0].y, gq[0].fc} !== 15'd0) begin
        failures++;
        $display("FAIL prime_pos got=%h/%h req=0/0",
                 gq[0].y, gq[0].fc);
      end
    end
    wait_drv(1, 200);
    if (dq.size() >= 1 && gq.size() >= 1) begin
      checks++;
      if (dq[0].cyc !== gq[0].cyc + 64 + 2) begin
        failures++;
        $display("FAIL first_drv_cycle got=%0d req=%0d",
                 dq[0].cyc - gq[0].cyc, 66);
      end
      checks++;
      if ({dq[0].y, dq[0].fc} !== 15'd0) begin
        failures++;
        $display("FAIL first_drv_pos got=%h/%h req=0/0",
                 dq[0].y, dq[0].fc);
      end
      checks++;
      if (gq.size() < 2 || gq[1].cyc !== dq[0].cyc ||
          gq[1].y !== 5'd1 || gq[1].fc !== 10'd1) begin
        failures++;
        $display("FAIL second_gen got=%0d req=2 y=1 fc=1",
                 gq.size());
      end
    end
  endtask

  task automatic test_full_scan;
    logic [9:0] want;
    gen_lo = 64; gen_hi = 64; drv_lo = 100; drv_hi = 140;
    wait_drv(ROW + 1, 6000);
    checks++;
    if (rd_count !== ROW) begin
      failures++;
      $display("FAIL scan_rows got=%0d req=%0d", rd_count, ROW);
    end
    checks++;
    if (fd_count !== 1) begin
      failures++;
      $display("FAIL scan_frames got=%0d req=1", fd_count);
    end
    foreach (dq[i]) begin
      checks++;
      if (dq[i].k !== i || dq[i].y !== slot_y(i) ||
          dq[i].fc !== slot_fc(i)) begin
        failures++;
        $display("FAIL drv_slot%0d got=%h/%h req=%h/%h",
                 i, dq[i].y, dq[i].fc, slot_y(i), slot_fc(i));
      end
    end
    foreach (gq[i]) begin
      want = gq[i].paired ? slot_fc(gq[i].k + 1)
                          : slot_fc(gq[i].k);
      checks++;
      if (gq[i].fc !== want) begin
        failures++;
        $display("FAIL gen_slot%0d got=%h req=%h",
                 i, gq[i].fc, want);
      end
    end
    if (dq.size() > ROW) begin
      checks++;
      if (dq[ROW].fc !== {9'd1, 1'b0}) begin
        failures++;
        $display("FAIL frame_wrap got=%h req=%h",
                 dq[ROW].fc, {9'd1, 1'b0});
      end
    end
  endtask

  task automatic test_stagger;
    int n;
    gen_lo = 64; gen_hi = 64; drv_lo = 84; drv_hi = 84;
    n = dq.size();
    wait_drv(n + 3, 600);
    gen_lo = 64; gen_hi = 64; drv_lo = 44; drv_hi = 44;
    n = dq.size();
    wait_drv(n + 3, 600);
    gen_lo = 20; gen_hi = 60; drv_lo = 20; drv_hi = 60;
    n = dq.size();
    wait_drv(n + 8, 1200);
    for (int i = n; i < dq.size(); i++) begin
      checks++;
      if (dq[i].y !== slot_y(dq[i].k) ||
          dq[i].fc !== slot_fc(dq[i].k)) begin
        failures++;
        $display("FAIL stagger_slot%0d got=%h/%h req=%h/%h",
                 dq[i].k, dq[i].y, dq[i].fc,
                 slot_y(dq[i].k), slot_fc(dq[i].k));
      end
    end
    checks++;
    if (rd_err !== 0) begin
      failures++;
      $display("FAIL stagger_row_done got=%0d req=0", rd_err);
    end
  endtask

  task automatic test_enable_drop;
    int n, g0, k0, t0;
    gen_lo = 64; gen_hi = 64; drv_lo = 80; drv_hi = 80;
    n = dq.size();
    wait_drv(n + 1, 400);
    repeat (5) @(posedge clock);
    #1;
    enable = 0;
    g0 = gq.size();
    k0 = rd_count;
    for (int i = 0; i < 400 && busy; i++) begin
      @(negedge clock); #1;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL drop_idle got=%b req=0", busy);
    end
    repeat (20) @(negedge clock);
    #1;
    checks++;
    if (gq.size() !== g0 || dq.size() !== n + 1) begin
      failures++;
      $display("FAIL drop_no_start got=%0d/%0d req=%0d/%0d",
               gq.size(), dq.size(), g0, n + 1);
    end
    checks++;
    if (rd_count !== k0 + 1) begin
      failures++;
      $display("FAIL drop_slot_done got=%0d req=%0d",
               rd_count, k0 + 1);
    end
    @(posedge clock); #1;
    t0 = cyc;
    enable = 1;
    wait_gen(g0 + 1, 20);
    if (gq.size() > g0) begin
      checks++;
      if (gq[g0].cyc !== t0 + 2 || gq[g0].y !== slot_y(k0 + 1) ||
          gq[g0].fc !== slot_fc(k0 + 1)) begin
        failures++;
        $display("FAIL reprime got=%0d %h/%h req=2 %h/%h",
                 gq[g0].cyc - t0, gq[g0].y, gq[g0].fc,
                 slot_y(k0 + 1), slot_fc(k0 + 1));
      end
    end
    wait_drv(n + 2, 300);
    if (dq.size() > n + 1) begin
      checks++;
      if (dq[n + 1].y !== slot_y(k0 + 1) ||
          dq[n + 1].fc !== slot_fc(k0 + 1)) begin
        failures++;
        $display("FAIL reprime_drv got=%h/%h req=%h/%h",
                 dq[n + 1].y, dq[n + 1].fc,
                 slot_y(k0 + 1), slot_fc(k0 + 1));
      end
    end
  endtask

  task automatic test_reset_midwait;
    int n, t0;
    gen_lo = 64; gen_hi = 64; drv_lo = 90; drv_hi = 90;
    n = dq.size();
    wait_drv(n + 1, 400);
    repeat (10) @(negedge clock);
    @(posedge clock); #3;
    reset = 0;
    #1;
    checks++;
    if ({gen_start, drv_start, row_done, frame_done, busy,
         gen_y, drv_y, gen_frame_count, drv_frame_count}
        !== 35'd0) begin
      failures++;
      $display("FAIL async_reset got=%h req=0",
        {gen_start, drv_start, row_done, frame_done, busy,
         gen_y, drv_y, gen_frame_count, drv_frame_count});
    end
    gq.delete();
    dq.delete();
    rd_count = 0;
    gen_is_idle = 1; drv_is_idle = 1;
    gen_left = 0; drv_left = 0;
    repeat (2) @(posedge clock);
    #1;
    t0 = cyc;
    reset = 1;
    wait_gen(1, 20);
    if (gq.size() >= 1) begin
      checks++;
      if (gq[0].cyc !== t0 + 2 || gq[0].y !== 5'd0 ||
          gq[0].fc !== 10'd0) begin
        failures++;
        $display("FAIL restart_gen got=%0d %h/%h req=2 0/0",
                 gq[0].cyc - t0, gq[0].y, gq[0].fc);
      end
    end
    wait_drv(1, 200);
    if (dq.size() >= 1) begin
      checks++;
      if (dq[0].y !== 5'd0 || dq[0].fc !== 10'd0) begin
        failures++;
        $display("FAIL restart_drv got=%h/%h req=0/0",
                 dq[0].y, dq[0].fc);
      end
    end
  endtask

  task automatic test_handshake;
    repeat (3) @(negedge clock);
    #1;
    checks++;
    if (rd_err !== 0) begin
      failures++;
      $display("FAIL row_done_rule got=%0d req=0", rd_err);
    end
    checks++;
    if (fd_err !== 0) begin
      failures++;
      $display("FAIL frame_done_rule got=%0d req=0", fd_err);
    end
    checks++;
    if (gen_viol !== 0) begin
      failures++;
      $display("FAIL gen_start_busy got=%0d req=0", gen_viol);
    end
    checks++;
    if (drv_viol !== 0) begin
      failures++;
      $display("FAIL drv_start_busy got=%0d req=0", drv_viol);
    end
  endtask

  initial begin
    test_reset;
    test_prime;
    test_full_scan;
    test_stagger;
    test_enable_drop;
    test_reset_midwait;
    test_handshake;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
